// File: rtl/hilo_div_unit.sv
// -----------------------------------------------------------------------------
// hilo_div_unit
//
// Iterative restoring divider with the architectural HI/LO registers for the
// EX stage. It produces one quotient bit per clock and follows MIPS div/divu
// semantics. HI holds the remainder and LO holds the quotient. Mthi/Mtlo
// writes are accepted only while the unit is idle.
//
// Timing: Start sampled in IDLE at edge E0, then WIDTH CALC edges, then one
// FIX edge. Done pulses for one cycle after E(WIDTH+1). Every request takes
// this latency, divide-by-zero included.
//
// Ports
//   Clock      in   rising-edge clock
//   Reset      in   asynchronous active-high reset
//   Start      in   division request, sampled only in IDLE
//   Signed     in   1 = div (signed), 0 = divu; sampled with Start
//   Dividend   in   [WIDTH] A operand, sampled with Start
//   Divisor    in   [WIDTH] B operand, sampled with Start
//   Abort      in   pipeline flush; cancels an in-flight division
//   MthiWe     in   write WrData into HI (IDLE only)
//   MtloWe     in   write WrData into LO (IDLE only)
//   WrData     in   [WIDTH] data for Mthi/Mtlo
//   Busy       out  division in progress (drives the stall logic)
//   Done       out  one-cycle pulse when a division updates HI/LO
//   DivByZero  out  last completed division had Divisor == 0
//   Hi         out  [WIDTH] HI register (remainder)
//   Lo         out  [WIDTH] LO register (quotient)
// -----------------------------------------------------------------------------
module hilo_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    input  logic             Abort,
    input  logic             MthiWe,
    input  logic             MtloWe,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_e;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e           state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH:0]   rem_q,     rem_d;      // partial remainder, one spare bit
    logic [WIDTH-1:0] quo_q,     quo_d;      // dividend magnitude shifting into quotient
    logic [WIDTH-1:0] dsr_q,     dsr_d;      // divisor magnitude
    logic [WIDTH-1:0] dvd_q,     dvd_d;      // raw dividend, returned on divide-by-zero
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q,    zero_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    logic             done_q,    done_d;
    logic             dbz_q,     dbz_d;

    // -------------------------------------------------------------------------
    // Operand preparation: magnitudes in signed mode. The magnitude of the most
    // negative value is 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit
    // number, so no extra bit is needed here.
    // -------------------------------------------------------------------------
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        a_neg = Signed & Dividend[WIDTH-1];
        b_neg = Signed & Divisor[WIDTH-1];
        a_mag = a_neg ? (~Dividend + ONE) : Dividend;
        b_mag = b_neg ? (~Divisor + ONE) : Divisor;
    end

    // -------------------------------------------------------------------------
    // One restoring step. The shifted remainder needs WIDTH+1 bits. The trial
    // difference gets one more bit so its sign can be read directly.
    // -------------------------------------------------------------------------
    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;

    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {2'b00, dsr_q};
        trial_neg = trial[WIDTH+1];
    end

    // -------------------------------------------------------------------------
    // Sign correction applied at FIX. The quotient is negative iff the operand
    // signs differ. The remainder takes the dividend's sign. The final
    // remainder is below the divisor magnitude, so its top bit is always clear.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        quo_fix = neg_quo_q ? (~quo_q + ONE) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q[WIDTH-1:0] + ONE) : rem_q[WIDTH-1:0];
    end

    // -------------------------------------------------------------------------
    // Next-state and register update logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d takes its _q value first. No path can then leave a
        // signal unassigned, so no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dsr_d     = dsr_q;
        dvd_d     = dvd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                // Mthi/Mtlo land only in IDLE. A division started in the same
                // cycle overwrites both registers later at its FIX edge.
                if (MthiWe) begin
                    hi_d = WrData;
                end
                if (MtloWe) begin
                    lo_d = WrData;
                end
                // Abort suppresses a Start that arrives in the same cycle.
                if (Start && !Abort) begin
                    state_d   = ST_CALC;
                    cnt_d     = CNT_LOAD;
                    rem_d     = '0;
                    quo_d     = a_mag;
                    dsr_d     = b_mag;
                    dvd_d     = Dividend;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    zero_d    = (Divisor == '0);
                end
            end

            ST_CALC: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (trial_neg) begin
                        rem_d = rem_shift[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_d = trial[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                if (!Abort) begin
                    done_d = 1'b1;
                    dbz_d  = zero_q;
                    if (zero_q) begin
                        // Divide-by-zero returns the untouched dividend and
                        // an all-ones quotient, whatever the signedness.
                        hi_d = dvd_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        // NOTE: non-blocking assignments, so every flop updates from the same
        // pre-edge values no matter what order the statements are in.
        if (Reset) begin
            // The datapath is cleared too, so a reset mid-division leaves no
            // stale partial result.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            dvd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dsr_q     <= dsr_d;
            dvd_q     <= dvd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Iterative multi-cycle divider with HI/LO registers for the EX stage.
- Responds to the ALU's Div requests and serves Mfhi/Mflo reads.
- Busy drives the hazard/stall logic; HI/LO feed the EX result mux.
- Restoring algorithm, one quotient bit per clock; MIPS signed and unsigned semantics.

Parameters:
WIDTH, 32, operand and result width in bits.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous active-high reset
Start  input  1  division request; sampled only in IDLE
Signed  input  1  1 = div (signed), 0 = divu; sampled with Start
Dividend  input  WIDTH  A operand; sampled with Start
Divisor  input  WIDTH  B operand; sampled with Start
Abort  input  1  pipeline flush; cancels an in-flight division
MthiWe  input  1  write WrData into HI
MtloWe  input  1  write WrData into LO
WrData  input  WIDTH  data for Mthi/Mtlo
Busy  output  1  division in progress
Done  output  1  one-cycle pulse when HI/LO are updated by a division
DivByZero  output  1  last completed division had Divisor == 0
Hi  output  WIDTH  HI register (remainder)
Lo  output  WIDTH  LO register (quotient)

Behaviour:
- Reset (async, any time, including mid-division):
  - Hi = 0, Lo = 0, Busy = 0, Done = 0, DivByZero = 0, state = IDLE.
  - Partial results are discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - Start = 1 at edge E0 latches operands and Signed, loads counter = WIDTH, and moves to CALC.
  - Busy = 1 from E0.
  - In signed mode, magnitudes are taken before iterating.
- CALC:
  - Each edge shifts the remainder/quotient pair left by 1, trial-subtracts the divisor magnitude, and restores the remainder if the result is negative.
  - The counter decrements each edge; after WIDTH edges (E1..EWIDTH) the state moves to FIX.
- FIX (edge E(WIDTH+1)):
  - Apply sign correction: quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - Write Hi = remainder, Lo = quotient.
  - Busy falls, Done = 1 for exactly one cycle; return to IDLE.
- Fixed latency: Start to Done = WIDTH+1 edges (33 for WIDTH=32). Every request takes this latency, including special cases.
- Divide by zero (Divisor == 0):
  - Full latency is still used.
  - Hi = Dividend (unmodified), Lo = all ones.
  - DivByZero = 1 with Done; it holds until the next completed division.
- Signed overflow (0x80000000 / 0xFFFFFFFF, Signed = 1):
  - Lo = 0x80000000, Hi = 0, DivByZero = 0.
- Arithmetic width:
  - Internal remainder is WIDTH+1 bits.
  - Magnitude of 0x80000000 is handled as unsigned 2^31 without overflow.
- Start while Busy: ignored. No queueing, no restart.
- Abort while Busy:
  - Next edge returns to IDLE; Hi/Lo unchanged; no Done; Busy = 0.
  - Abort in IDLE has no effect.
  - Abort and Start in the same IDLE cycle: Start is ignored.
- Mthi/Mtlo:
  - In IDLE, the write takes effect at the edge.
  - While Busy, the write is ignored; the pipeline must stall on Busy.
  - MthiWe and MtloWe together write both registers.
  - Start + MthiWe/MtloWe in the same IDLE cycle: the write occurs, the division starts, and its result later overwrites both registers.
- Hi/Lo are stable except at a FIX edge, an IDLE Mthi/Mtlo write, or Reset.

Test Plan:
- Reset, unsigned 6/3, wait 33 edges -> Done pulse one cycle, Hi=0, Lo=2, DivByZero=0, Busy high exactly 33 cycles.
- Unsigned 1/3 -> Hi=1, Lo=0; unsigned 11/3 -> Hi=2, Lo=3; a Start issued mid-operation is ignored and the results are unchanged.
- Start 10/3, assert Reset at edge 10 -> Hi=0, Lo=0, Busy=0, no Done. Then 11/3 -> Hi=2, Lo=3.
- Signed -7/2 (0xFFFFFFF9 / 2) -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Divisor 0 with Dividend 0x1234 -> after 33 edges Hi=0x1234, Lo=0xFFFFFFFF, DivByZero=1. A following 6/3 clears DivByZero.
- Mthi 0xAAAA in IDLE -> Hi=0xAAAA next edge. Start 9/2 then Abort at edge 5 -> Hi=0xAAAA unchanged, no Done. MtloWe while Busy -> Lo unchanged.
